// File: rtl/multicycle_controller.sv
// Multicycle RISC-V-style controller: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps, plus combinational ALU/immediate decode.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | load IR from memory, PC <= PC + 4
// DECODE   | read registers, compute PC + imm; flag unsupported ops
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | read data memory at computed address
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECUTER | R-type ALU operation rs1 op rs2
// EXECUTEI | I-type ALU operation rs1 op imm
// ALUWB    | write ALU result to rd
// BEQ      | compare rs1 - rs2, take branch when Zero
// JAL      | PC <= target, compute link address PC + 4
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } stateT;

  stateT state, nextState;

  logic       opLegal;
  logic       pcUpdate, branch, irWriteRaw, regWriteRaw, memWriteRaw, doneRaw;
  logic [1:0] aluOp;

  // State register; reset parks the machine in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nextState;
  end

  // Supported opcode detection, used in DECODE
  always_comb begin
    opLegal = 1'b0;
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011,
      7'b0010011, 7'b1100011, 7'b1101111: opLegal = 1'b1;
      default:                            opLegal = 1'b0;
    endcase
  end

  // Next-state logic and Moore outputs
  always_comb begin
    nextState   = FETCH;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memWriteRaw = 1'b0;
    doneRaw     = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    aluOp       = 2'b00;
    case (state)
      FETCH: begin
        nextState  = DECODE;
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcUpdate   = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nextState = MEMADR;
          7'b0110011:             nextState = EXECUTER;
          7'b0010011:             nextState = EXECUTEI;
          7'b1100011:             nextState = BEQ;
          7'b1101111:             nextState = JAL;
          default:                nextState = FETCH;
        endcase
        doneRaw = ~opLegal;
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextState = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        nextState = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA   = 2'b10;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
        doneRaw = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        nextState = ALUWB;
      end
      default: nextState = FETCH;
    endcase
  end

  // Write enables and pulses are held off while reset is asserted, since the
  // reset state FETCH would otherwise request IR and PC writes
  always_comb begin
    PCWrite   = rst_n & (pcUpdate | (branch & Zero));
    IRWrite   = rst_n & irWriteRaw;
    RegWrite  = rst_n & regWriteRaw;
    MemWrite  = rst_n & memWriteRaw;
    InstrDone = rst_n & doneRaw;
    IllegalOp = rst_n & (state == DECODE) & ~opLegal;
  end

  // Immediate format select, decoded from op in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // ALU operation decode; subtract for R-type only when op[5] and funct7b5
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes its
// expected per-cycle output vectors, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       InstrDone, IllegalOp;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  typedef enum {FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
                EXECUTER, EXECUTEI, ALUWB, BEQ, JAL} tbState;

  typedef struct {
    string       tag;
    logic [17:0] vec;
  } expEntry;

  expEntry scoreQ[$];
  int testsRun    = 0;
  int testsFailed = 0;

  logic [17:0] obsVec;
  assign obsVec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, IllegalOp};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference outputs for one cycle in state s
  function automatic logic [17:0] expOut(tbState s, logic [6:0] o, logic [2:0] f3,
                                         logic f7, logic z, logic inRst);
    logic pcw, adr, mw, irw, rw, done, ill, legal;
    logic [1:0] rs, sa, sb, imm, aluOp;
    logic [2:0] ac;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aluOp = 2'b00;
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    case (s)
      FETCH:    begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      DECODE:   begin sa = 2'b01; sb = 2'b01; ill = !legal; done = !legal; end
      MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      MEMREAD:  begin adr = 1; end
      MEMWB:    begin rs = 2'b01; rw = 1; done = 1; end
      MEMWRITE: begin adr = 1; mw = 1; done = 1; end
      EXECUTER: begin sa = 2'b10; aluOp = 2'b10; end
      EXECUTEI: begin sa = 2'b10; sb = 2'b01; aluOp = 2'b10; end
      ALUWB:    begin rw = 1; done = 1; end
      BEQ:      begin sa = 2'b10; aluOp = 2'b01; pcw = z; done = 1; end
      JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default:  ;
    endcase
    if (o == 7'b0100011)      imm = 2'b01;
    else if (o == 7'b1100011) imm = 2'b10;
    else if (o == 7'b1101111) imm = 2'b11;
    else                      imm = 2'b00;
    if (aluOp == 2'b00)      ac = 3'b000;
    else if (aluOp == 2'b01) ac = 3'b001;
    else if (f3 == 3'b000)   ac = (o[5] && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010)   ac = 3'b101;
    else if (f3 == 3'b110)   ac = 3'b011;
    else if (f3 == 3'b111)   ac = 3'b010;
    else                     ac = 3'b000;
    if (inRst) begin pcw = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0; end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac, done, ill};
  endfunction

  // Drive one instruction starting in its FETCH cycle; stopAfter > 0 truncates it
  task automatic runInstr(input string name, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic z, input int stopAfter);
    tbState seq[$];
    int n;
    expEntry e;
    seq.push_back(FETCH);
    seq.push_back(DECODE);
    case (o)
      7'b0000011: begin seq.push_back(MEMADR); seq.push_back(MEMREAD); seq.push_back(MEMWB); end
      7'b0100011: begin seq.push_back(MEMADR); seq.push_back(MEMWRITE); end
      7'b0110011: begin seq.push_back(EXECUTER); seq.push_back(ALUWB); end
      7'b0010011: begin seq.push_back(EXECUTEI); seq.push_back(ALUWB); end
      7'b1100011: seq.push_back(BEQ);
      7'b1101111: begin seq.push_back(JAL); seq.push_back(ALUWB); end
      default: ;
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    n = (stopAfter > 0) ? stopAfter : seq.size();
    for (int i = 0; i < n; i++) begin
      e.tag = $sformatf("%s c%0d", name, i + 1);
      e.vec = expOut(seq[i], o, f3, f7, z, 1'b0);
      scoreQ.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    expEntry e;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkVal(e.tag, {14'd0, obsVec}, {14'd0, e.vec});
    end
  end

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    #3;
    checkVal("reset initial", {14'd0, obsVec}, {14'd0, expOut(FETCH, op, funct3, funct7b5, Zero, 1'b1)});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    runInstr("lw",        7'b0000011, 3'b010, 1'b0, 1'b1, 0);
    runInstr("sw",        7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    runInstr("sub",       7'b0110011, 3'b000, 1'b1, 1'b1, 0);
    runInstr("add",       7'b0110011, 3'b000, 1'b0, 1'b0, 0);
    runInstr("slt",       7'b0110011, 3'b010, 1'b0, 1'b0, 0);
    runInstr("addi_f7",   7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    runInstr("ori",       7'b0010011, 3'b110, 1'b0, 1'b0, 0);
    runInstr("andi",      7'b0010011, 3'b111, 1'b0, 1'b1, 0);
    runInstr("xori",      7'b0010011, 3'b100, 1'b0, 1'b0, 0);
    runInstr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    runInstr("beq_not",   7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    runInstr("jal",       7'b1101111, 3'b000, 1'b0, 1'b0, 0);
    runInstr("ill_ff",    7'b1111111, 3'b000, 1'b0, 1'b0, 0);
    runInstr("ill_00",    7'b0000000, 3'b000, 1'b0, 1'b1, 0);
    runInstr("lw_after",  7'b0000011, 3'b000, 1'b0, 1'b0, 0);

    // Abort lw in MEMREAD: run three cycles, then assert reset mid-cycle
    runInstr("lw_abort",  7'b0000011, 3'b000, 1'b0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    checkVal("reset in MEMREAD", {14'd0, obsVec}, {14'd0, expOut(FETCH, op, funct3, funct7b5, Zero, 1'b1)});
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset held", {14'd0, obsVec}, {14'd0, expOut(FETCH, op, funct3, funct7b5, Zero, 1'b1)});
    rst_n = 1'b1;
    runInstr("addi_restart", 7'b0010011, 3'b000, 1'b0, 1'b0, 0);
    runInstr("sw_restart",   7'b0100011, 3'b000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20 && scoreQ.size() > 0; i++) @(negedge clk);
    if (scoreQ.size() > 0) checkVal("scoreboard drain", scoreQ.size(), 0);
    #2;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
